sr_cmd_debouncer: RTL and testbench

//  Upstream command stage for the SR latch: turns two raw, bouncy push-button inputs (SET, RESET) into clean s/r/en.

---
 rtl/sr_cmd_pkg.sv | 37 +++
 rtl/sr_btn_debounce.sv | 85 ++++++++
 rtl/sr_cmd_checker.sv | 21 ++
 rtl/sr_cmd_debouncer.sv | 210 +++++++++++++++++++++
 tb/tb_sr_cmd_debouncer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sr_cmd_pkg.sv
// -----------------------------------------------------------------------------
// sr_cmd_pkg
// Shared types and constants for the SR-latch command front end.
//   sr_state_e        : command FSM states (IDLE, DRIVE, GAP)
//   sr_cmd_e          : one-hot-ish s/r command encoding, bit1 = s, bit0 = r
//   CONFLICT_CNT_W/MAX: width and ceiling of the optional conflict tally
//   sat_inc_conflict  : saturating increment used by the conflict tally
// -----------------------------------------------------------------------------
package sr_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } sr_state_e;

    // Bit 1 drives s, bit 0 drives r; 2'b11 is deliberately not a member.
    typedef enum logic [1:0] {
        CMD_NONE = 2'b00,
        CMD_SET  = 2'b10,
        CMD_RST  = 2'b01
    } sr_cmd_e;

    localparam int                        CONFLICT_CNT_W   = 8;
    localparam logic [CONFLICT_CNT_W-1:0] CONFLICT_CNT_MAX = 8'hFF;

    function automatic logic [CONFLICT_CNT_W-1:0] sat_inc_conflict(
        input logic [CONFLICT_CNT_W-1:0] value
    );
        if (value == CONFLICT_CNT_MAX) begin
            return value;
        end else begin
            return value + 8'd1;
        end
    endfunction

endpackage

// File: rtl/sr_btn_debounce.sv
// -----------------------------------------------------------------------------
// sr_btn_debounce
// One button channel: 2-FF synchroniser, stable-sample debounce counter and
// press-edge detector.
// Parameters:
//   CNT_W        width of the debounce counter (2**CNT_W > DEBOUNCE_CYC)
//   DEBOUNCE_CYC consecutive differing samples needed to flip the level
// Ports:
//   clk      in  system clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   btn_i    in  raw asynchronous button, active-high
//   deb_o    out debounced level
//   press_o  out 1-cycle pulse when the debounced level rises 0->1
// -----------------------------------------------------------------------------
module sr_btn_debounce #(
    parameter int CNT_W        = 16,
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic deb_o,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             deb_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    logic             deb_next_s;
    logic             press_next_s;
    logic [CNT_W-1:0] cnt_next_s;

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_i;
            sync2_r <= sync1_r;
        end
    end

    // Debounce decision: count differing samples, flip on the last one
    always_comb begin
        deb_next_s   = deb_r;
        press_next_s = 1'b0;
        cnt_next_s   = '0;
        if (sync2_r != deb_r) begin
            if (cnt_r == CNT_LAST) begin
                deb_next_s   = ~deb_r;
                cnt_next_s   = '0;
                // Only the 0->1 flip is a press; release is silent.
                press_next_s = ~deb_r;
            end else begin
                cnt_next_s   = cnt_r + CNT_ONE;
            end
        end else begin
            cnt_next_s = '0;
        end
    end

    // Debounce state and registered press pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_r   <= 1'b0;
            press_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            deb_r   <= deb_next_s;
            press_r <= press_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    assign deb_o   = deb_r;
    assign press_o = press_r;

endmodule

// File: rtl/sr_cmd_checker.sv
// -----------------------------------------------------------------------------
// sr_cmd_checker
// Protocol checks on the latch command outputs: s and r are never high
// together, and s/r are low whenever en is low.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   s, r, en    command outputs being observed
// -----------------------------------------------------------------------------
module sr_cmd_checker (
    input logic clk,
    input logic rst_n,
    input logic s,
    input logic r,
    input logic en
);

    a_sr_exclusive : assert property (@(posedge clk) disable iff (!rst_n) !(s && r));

    a_en_qualifies : assert property (@(posedge clk) disable iff (!rst_n) (!en) |-> (!s && !r));

endmodule

// File: rtl/sr_cmd_debouncer.sv
// -----------------------------------------------------------------------------
// sr_cmd_debouncer
// Turns raw SET/RESET push buttons into clean s/r/en commands for an SR latch.
// Each button is synchronised and debounced; its press edge raises a pending
// request. A three-state FSM (IDLE -> DRIVE -> GAP) serves one request at a
// time with an en pulse of PULSE_CYC cycles, followed by a mandatory low gap.
// Simultaneously pending SET and RESET requests are dropped and flagged.
// Parameters:
//   CNT_W        debounce counter width (2**CNT_W > DEBOUNCE_CYC)
//   DEBOUNCE_CYC stable samples needed to flip a debounced level (>=2)
//   PULSE_CYC    en high time per command in clk cycles (>=1)
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   set_btn_i, rst_btn_i  raw SET / RESET buttons
//   s, r, en              registered latch command outputs
//   busy                  FSM not in IDLE
//   conflict              1-cycle pulse when both requests meet in IDLE
//   conflict_cnt[7:0]     saturating conflict tally, only with
//                         SR_CMD_CONFLICT_CNT_EN defined
// -----------------------------------------------------------------------------
module sr_cmd_debouncer
    import sr_cmd_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int PULSE_CYC    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_btn_i,
    input  logic rst_btn_i,
    output logic s,
    output logic r,
    output logic en,
    output logic busy,
    output logic conflict
`ifdef SR_CMD_CONFLICT_CNT_EN
    ,
    output logic [CONFLICT_CNT_W-1:0] conflict_cnt
`endif
);

    localparam int               PULSE_W    = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_CYC - 1);
    localparam logic [PULSE_W-1:0] PULSE_ONE  = PULSE_W'(1);

    logic set_press_s;
    logic rst_press_s;
    logic unused_set_deb_s;
    logic unused_rst_deb_s;

    sr_btn_debounce #(
        .CNT_W        (CNT_W),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_set_deb (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (set_btn_i),
        .deb_o   (unused_set_deb_s),
        .press_o (set_press_s)
    );

    sr_btn_debounce #(
        .CNT_W        (CNT_W),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_rst_deb (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (rst_btn_i),
        .deb_o   (unused_rst_deb_s),
        .press_o (rst_press_s)
    );

    sr_state_e          state_r;
    sr_state_e          state_next_s;
    logic [PULSE_W-1:0] pulse_cnt_r;
    logic [PULSE_W-1:0] pulse_cnt_next_s;
    sr_cmd_e            cmd_next_s;
    logic               en_next_s;
    logic               conflict_next_s;
    logic               busy_next_s;

    logic set_pend_r;
    logic rst_pend_r;
    logic set_clr_s;
    logic rst_clr_s;
    logic set_pend_next_s;
    logic rst_pend_next_s;

    logic s_r;
    logic r_r;
    logic en_r;
    logic busy_r;
    logic conflict_r;

    // Next state and next registered outputs of the command FSM
    always_comb begin
        state_next_s     = state_r;
        pulse_cnt_next_s = pulse_cnt_r;
        cmd_next_s       = (s_r || r_r) ? (s_r ? CMD_SET : CMD_RST) : CMD_NONE;
        en_next_s        = en_r;
        conflict_next_s  = 1'b0;
        set_clr_s        = 1'b0;
        rst_clr_s        = 1'b0;
        case (state_r)
            IDLE: begin
                cmd_next_s = CMD_NONE;
                en_next_s  = 1'b0;
                if (set_pend_r && rst_pend_r) begin
                    // Contradictory requests: drop both rather than guess.
                    conflict_next_s = 1'b1;
                    set_clr_s       = 1'b1;
                    rst_clr_s       = 1'b1;
                end else if (set_pend_r) begin
                    cmd_next_s       = CMD_SET;
                    en_next_s        = 1'b1;
                    set_clr_s        = 1'b1;
                    pulse_cnt_next_s = '0;
                    state_next_s     = DRIVE;
                end else if (rst_pend_r) begin
                    cmd_next_s       = CMD_RST;
                    en_next_s        = 1'b1;
                    rst_clr_s        = 1'b1;
                    pulse_cnt_next_s = '0;
                    state_next_s     = DRIVE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DRIVE: begin
                // The loading cycle already counts as the first en cycle.
                if (pulse_cnt_r == PULSE_LAST) begin
                    cmd_next_s       = CMD_NONE;
                    en_next_s        = 1'b0;
                    pulse_cnt_next_s = '0;
                    state_next_s     = GAP;
                end else begin
                    pulse_cnt_next_s = pulse_cnt_r + PULSE_ONE;
                end
            end
            GAP: begin
                cmd_next_s   = CMD_NONE;
                en_next_s    = 1'b0;
                state_next_s = IDLE;
            end
            default: begin
                cmd_next_s       = CMD_NONE;
                en_next_s        = 1'b0;
                pulse_cnt_next_s = '0;
                state_next_s     = IDLE;
            end
        endcase
    end

    // A fresh press wins over a clear in the same cycle, so it is never lost
    always_comb begin
        set_pend_next_s = set_press_s | (set_pend_r & ~set_clr_s);
        rst_pend_next_s = rst_press_s | (rst_pend_r & ~rst_clr_s);
        busy_next_s     = (state_next_s != IDLE);
    end

    // FSM state, pulse counter, pending flags and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pulse_cnt_r <= '0;
            set_pend_r  <= 1'b0;
            rst_pend_r  <= 1'b0;
            s_r         <= 1'b0;
            r_r         <= 1'b0;
            en_r        <= 1'b0;
            busy_r      <= 1'b0;
            conflict_r  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            pulse_cnt_r <= pulse_cnt_next_s;
            set_pend_r  <= set_pend_next_s;
            rst_pend_r  <= rst_pend_next_s;
            s_r         <= cmd_next_s[1] & en_next_s;
            r_r         <= cmd_next_s[0] & en_next_s;
            en_r        <= en_next_s;
            busy_r      <= busy_next_s;
            conflict_r  <= conflict_next_s;
        end
    end

    assign s        = s_r;
    assign r        = r_r;
    assign en       = en_r;
    assign busy     = busy_r;
    assign conflict = conflict_r;

`ifdef SR_CMD_CONFLICT_CNT_EN
    logic [CONFLICT_CNT_W-1:0] conflict_cnt_r;

    // Saturating tally of conflict pulses, cleared only by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt_r <= '0;
        end else if (conflict_next_s) begin
            conflict_cnt_r <= sat_inc_conflict(conflict_cnt_r);
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    assign conflict_cnt = conflict_cnt_r;
`endif

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// -----------------------------------------------------------------------------
// tb_sr_cmd_debouncer
// Self-checking bench for sr_cmd_debouncer (DEBOUNCE_CYC=4, PULSE_CYC=2).
// A behavioural model predicts every output after every clock edge:
// button samples are delayed two edges, a level flips once the last
// DEBOUNCE_CYC samples all disagree with it, and a command occupies a
// window of edges [start, start+PULSE_CYC] before the FSM can accept again.
// Directed scenarios are followed by randomized button activity.
// Define SR_CMD_CONFLICT_CNT_EN to also cover conflict_cnt.
// -----------------------------------------------------------------------------
module tb_sr_cmd_debouncer;

    localparam int DEB   = 4;
    localparam int PUL   = 2;
    localparam int CNT_W = 4;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic set_btn_i = 1'b0;
    logic rst_btn_i = 1'b0;
    logic s;
    logic r;
    logic en;
    logic busy;
    logic conflict;
`ifdef SR_CMD_CONFLICT_CNT_EN
    logic [7:0] conflict_cnt;
`endif

    always #5 clk = ~clk;

    sr_cmd_debouncer #(
        .CNT_W        (CNT_W),
        .DEBOUNCE_CYC (DEB),
        .PULSE_CYC    (PUL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_btn_i (set_btn_i),
        .rst_btn_i (rst_btn_i),
        .s         (s),
        .r         (r),
        .en        (en),
        .busy      (busy),
        .conflict  (conflict)
`ifdef SR_CMD_CONFLICT_CNT_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    sr_cmd_checker u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (s),
        .r     (r),
        .en    (en)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int edge_n  = 0;
    int start_m = -1000;
    bit cmd_set_m;
    bit confl_m;
    int ccnt_m;
    bit pipe1 [2];
    bit pipe2 [2];
    bit hist  [2][DEB];
    bit deb_m [2];
    bit press_m [2];
    bit pend_m [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        start_m = -1000;
        confl_m = 1'b0;
        cmd_set_m = 1'b0;
        ccnt_m  = 0;
        for (int c = 0; c < 2; c++) begin
            pipe1[c] = 1'b0;
            pipe2[c] = 1'b0;
            deb_m[c] = 1'b0;
            press_m[c] = 1'b0;
            pend_m[c] = 1'b0;
            for (int i = 0; i < DEB; i++) hist[c][i] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit sv, input bit rv);
        bit served [2];
        bit raw [2];
        bit sample;
        bit all_diff;
        edge_n++;
        served[0] = 1'b0;
        served[1] = 1'b0;
        confl_m   = 1'b0;
        // The FSM can take a new decision once the previous window has passed
        if (edge_n >= start_m + PUL + 2) begin
            if (pend_m[0] && pend_m[1]) begin
                confl_m = 1'b1;
                served[0] = 1'b1;
                served[1] = 1'b1;
                if (ccnt_m < 255) ccnt_m++;
            end else if (pend_m[0]) begin
                start_m = edge_n; cmd_set_m = 1'b1; served[0] = 1'b1;
            end else if (pend_m[1]) begin
                start_m = edge_n; cmd_set_m = 1'b0; served[1] = 1'b1;
            end
        end
        for (int c = 0; c < 2; c++) pend_m[c] = press_m[c] | (pend_m[c] & ~served[c]);
        raw[0] = sv;
        raw[1] = rv;
        for (int c = 0; c < 2; c++) begin
            sample   = pipe2[c];
            pipe2[c] = pipe1[c];
            pipe1[c] = raw[c];
            for (int i = 0; i < DEB - 1; i++) hist[c][i] = hist[c][i + 1];
            hist[c][DEB - 1] = sample;
            all_diff = 1'b1;
            for (int i = 0; i < DEB; i++) if (hist[c][i] == deb_m[c]) all_diff = 1'b0;
            press_m[c] = 1'b0;
            if (all_diff) begin
                deb_m[c]   = ~deb_m[c];
                press_m[c] = deb_m[c];
            end
        end
    endtask

    task automatic compare_outputs();
        int  d;
        bit  en_e;
        bit  busy_e;
        d      = edge_n - start_m;
        en_e   = (d >= 0) && (d < PUL);
        busy_e = (d >= 0) && (d <= PUL);
        check_eq("outs{s,r,en,busy,conflict}", {s, r, en, busy, conflict},
                 {en_e & cmd_set_m, en_e & ~cmd_set_m, en_e, busy_e, confl_m});
        check_eq("s_and_r", {31'd0, s & r}, 32'd0);
        check_eq("en_low_sr", {31'd0, (~en) & (s | r)}, 32'd0);
`ifdef SR_CMD_CONFLICT_CNT_EN
        check_eq("conflict_cnt", conflict_cnt, ccnt_m);
`endif
    endtask

    task automatic step(input bit sv, input bit rv);
        set_btn_i = sv;
        rst_btn_i = rv;
        @(posedge clk);
        if (rst_n) model_edge(sv, rv);
        else model_reset();
        #1;
        compare_outputs();
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_outs", {s, r, en, busy, conflict}, 32'd0);
        model_reset();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        int lat;
        int en_cnt;
        int pulses;
        int confl_cnt;
        int gap_len;
        int min_gap;
        bit prev_en;
        bit hold_v [2];
        int hold_n [2];

        model_reset();
        // 1. Reset state
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_eq("reset_outs", {s, r, en, busy, conflict}, 32'd0);
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0);

        // 2. Clean SET press: latency and pulse width
        lat = 0; en_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0);
            if (en && lat == 0) lat = i;
            if (en) en_cnt++;
            if (en) check_eq("set_cmd_sr", {s, r}, 32'd2);
        end
        check_eq("set_latency", lat, 8);
        check_eq("set_pulse_len", en_cnt, PUL);
        en_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0);
            if (en) en_cnt++;
        end
        check_eq("release_no_cmd", en_cnt, 0);

        // 3. Bouncing SET then stable; short bursts are rejected
        pulses = 0; prev_en = 1'b0;
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            step((i < 12), 1'b0);
            if (en && !prev_en) pulses++;
            prev_en = en;
        end
        check_eq("bounce_one_cmd", pulses, 1);
        en_cnt = 0;
        for (int i = 0; i < 13; i++) begin
            step((i < DEB - 1), 1'b0);
            if (en) en_cnt++;
        end
        check_eq("short_burst", en_cnt, 0);

        // 4. Simultaneous SET and RESET presses
        en_cnt = 0; confl_cnt = 0;
        for (int i = 0; i < 22; i++) begin
            step((i < 10), (i < 10));
            if (en) en_cnt++;
            if (conflict) confl_cnt++;
        end
        check_eq("conflict_pulses", confl_cnt, 1);
        check_eq("conflict_no_en", en_cnt, 0);
`ifdef SR_CMD_CONFLICT_CNT_EN
        check_eq("conflict_cnt_one", conflict_cnt, 32'd1);
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 14; i++) step((i < 7), (i < 7));
        end
        check_eq("conflict_cnt_sat", conflict_cnt, 32'd255);
`endif

        // 5. RESET pressed while SET is being driven
        pulses = 0; prev_en = 1'b0; gap_len = 0; min_gap = 1000; lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (en) lat = 1;
            step((i < 14), (lat != 0) && (i < 30));
            if (en && !prev_en) begin
                pulses++;
                if (pulses == 2) begin
                    check_eq("second_is_reset", {s, r}, 32'd1);
                    if (gap_len < min_gap) min_gap = gap_len;
                end
            end
            if (!en && pulses > 0) gap_len++;
            if (en) gap_len = 0;
            prev_en = en;
        end
        check_eq("two_pulses", pulses, 2);
        check_eq("gap_ge_2", {31'd0, min_gap >= 2}, 32'd1);

        // 1b. Reset in the middle of a DRIVE pulse
        lat = 0;
        for (int i = 0; i < 20 && lat == 0; i++) begin
            step(1'b1, 1'b0);
            if (en) lat = 1;
        end
        check_eq("drive_reached", lat, 1);
        async_reset();
        en_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b0);
            if (en) en_cnt++;
        end
        check_eq("post_reset_quiet", en_cnt, 0);

        // Randomized button activity against the model
        for (int c = 0; c < 2; c++) begin
            hold_v[c] = 1'b0;
            hold_n[c] = 0;
        end
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (hold_n[c] == 0) begin
                    hold_v[c] = $urandom_range(0, 1) != 0;
                    hold_n[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 16))
                                                             : int'($urandom_range(1, 4));
                end
                hold_n[c]--;
            end
            step(hold_v[0], hold_v[1]);
            if ($urandom_range(0, 399) == 0) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
